vc_scheduler: RTL and testbench
===============================

// Module: vc_scheduler
// PURPOSE
//  Weighted-priority scheduler between the VC0/VC1 virtual-channel FIFOs and the D0/D1 destination FIFOs.
//  Decides each cycle which VC FIFO to pop and routes the popped word to D0 or D1 by its destination bit.
//  Throttles on destination almost_full and flags any push into a full destination.
//  Sits in the transmission layer between the initial logic (VC FIFOs) and the destination FIFOs.
// PARAMETERS
//  DATA_WIDTH  6  word width of VC and D FIFO data
//  DEST_BIT    4  bit of the word selecting the destination: 0 -> D0, 1 -> D1
//  WEIGHT_VC0  3  max consecutive VC0 grants while VC1 is non-empty; legal range 1..15
// PORTS
//  clk             in   1           clock, rising edge
//  reset           in   1           synchronous, active-high
//  empty_fifo_VC0  in   1           VC0 FIFO empty
//  empty_fifo_VC1  in   1           VC1 FIFO empty
//  data_out_VC0    in   DATA_WIDTH  VC0 read data, valid the cycle after pop
//  data_out_VC1    in   DATA_WIDTH  VC1 read data, valid the cycle after pop
//  almost_full_D0  in   1           D0 FIFO almost full; asserts with >=3 free entries
//  almost_full_D1  in   1           D1 FIFO almost full; asserts with >=3 free entries
//  full_D0         in   1           D0 FIFO full
//  full_D1         in   1           D1 FIFO full
//  pop_VC0_fifo    out  1           pop VC0; combinational from state, counter and flags
//  pop_VC1_fifo    out  1           pop VC1; combinational from state, counter and flags
//  push_D0         out  1           push data_out_D into D0; registered
//  push_D1         out  1           push data_out_D into D1; registered
//  data_out_D      out  DATA_WIDTH  word for D0/D1; registered
//  idle            out  1           high in IDLE state
//  error_out       out  1           sticky: a push was issued while the target FIFO was full
//  state           out  3           FSM state code
// BEHAVIOUR
//  Reset: state=INIT(3'b001). pop_*, push_*, error_out = 0; data_out_D = 0; weight counter cnt = 0.
//  Reset also clears the in-flight pipeline; in-flight words are dropped. push_* is low the cycle after reset.
//  FSM:
//    INIT(001): held for 1 cycle after reset deasserts, no pops; then -> IDLE.
//    IDLE(010): both VC FIFOs empty; idle=1.
//      Any VC non-empty and no almost_full -> ACTIVE.
//      Any VC non-empty and any almost_full -> PAUSE.
//    ACTIVE(100): pop permitted.
//      Both VC FIFOs empty -> IDLE; this takes priority over PAUSE.
//      Otherwise, almost_full_D0 or almost_full_D1 -> PAUSE.
//    PAUSE(011): no pops.
//      Both almost_full low and a VC non-empty -> ACTIVE.
//      Both almost_full low and both VC empty -> IDLE.
//  Throttling is conservative: any almost_full blocks all pops, because the destination is not known before the read.
//  Grant in ACTIVE (at most one pop per cycle; never pop an empty FIFO):
//    Only VC0 non-empty -> pop VC0; cnt unchanged.
//    Only VC1 non-empty -> pop VC1; cnt = 0.
//    Both non-empty and cnt < WEIGHT_VC0 -> pop VC0; cnt = cnt + 1.
//    Both non-empty and cnt == WEIGHT_VC0 -> pop VC1; cnt = 0.
//  cnt is 4 bits and saturates at WEIGHT_VC0. It is unchanged in IDLE and PAUSE.
//  Empty flags update the cycle after a pop, so back-to-back pops every cycle are allowed.
//  Pipeline: pop at cycle N -> VC data valid in N+1 -> registered at end of N+1 -> push_Dx high in N+2 (latency 2).
//    Register a 1-bit valid and 1-bit source-select per stage.
//  Routing: data[DEST_BIT]=0 -> push_D0; =1 -> push_D1. Exactly one push per popped word; push_D0 and push_D1 never both high.
//  Words leave in pop order; there is no reordering between VCs.
//  Error: if push_Dx is high while full_Dx is high, error_out is set next cycle and held until reset. The push is still issued.
//  Entering PAUSE does not cancel the up to 2 in-flight words; they complete.
// TESTING
//  1. Reset held 2 cycles, then released -> state 001 for 1 cycle, then 010; all pops/pushes 0; error_out 0.
//  2. VC0 holds 0x05, 0x15 with VC1 empty -> pops VC0 at N and N+1;
//     push_D0 with 0x05 at N+2; push_D1 with 0x15 at N+3; then state -> IDLE.
//  3. Both VCs hold 8 words, WEIGHT_VC0=3, no backpressure -> grant order 0,0,0,1,0,0,0,1,...;
//     VC1 served once every 4 pops until VC0 drains.
//  4. almost_full_D1 rises mid-burst -> pops stop the same cycle, state PAUSE, the 2 in-flight words still pushed;
//     almost_full_D1 falls -> pops resume the next cycle.
//  5. full_D0 forced high while word 0x00 is in flight -> push_D0 still issued; error_out=1 next cycle and sticky through traffic.
//  6. reset asserted one cycle after a pop -> no push appears; after release, state=INIT, cnt=0, data_out_D=0.

Source files
------------

// File: rtl/vc_scheduler_if.sv
// vc_scheduler_if
//   Bundles the scheduler's FIFO-facing signals: VC FIFO status and read data in,
//   pop strobes out, destination FIFO status in, push strobes and write data out,
//   plus the idle/error/state status outputs.
//   master : the scheduler side (drives pops, pushes, data_out_D, status).
//   slave  : the FIFO/environment side (drives empty/almost_full/full and VC data).
interface vc_scheduler_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  empty_fifo_VC0;
  logic                  empty_fifo_VC1;
  logic [DATA_WIDTH-1:0] data_out_VC0;
  logic [DATA_WIDTH-1:0] data_out_VC1;
  logic                  almost_full_D0;
  logic                  almost_full_D1;
  logic                  full_D0;
  logic                  full_D1;
  logic                  pop_VC0_fifo;
  logic                  pop_VC1_fifo;
  logic                  push_D0;
  logic                  push_D1;
  logic [DATA_WIDTH-1:0] data_out_D;
  logic                  idle;
  logic                  error_out;
  logic [2:0]            state;

  modport master (
    input  empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
           almost_full_D0, almost_full_D1, full_D0, full_D1,
    output pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_out_D,
           idle, error_out, state
  );

  modport slave (
    output empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
           almost_full_D0, almost_full_D1, full_D0, full_D1,
    input  pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_out_D,
           idle, error_out, state
  );
endinterface

// File: rtl/vc_scheduler.sv
// vc_scheduler
//   Weighted-priority scheduler between the VC0/VC1 FIFOs and the D0/D1
//   destination FIFOs. Pops at most one VC word per cycle, routes it two cycles
//   later to D0 or D1 by data[DEST_BIT], throttles on any almost_full, and
//   raises a sticky error if a push lands on a full destination.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : vc_scheduler_if.master (VC status/data in, pops out, D status in,
//            pushes/data_out_D out, idle, error_out, state)
//
//   state  | meaning
//   -------+-------------------------------------------------
//   INIT   | one cycle after reset, no pops
//   IDLE   | both VC FIFOs empty, idle=1
//   PAUSE  | a destination is almost full, no pops
//   ACTIVE | pops permitted, weighted grant between VC0/VC1
module vc_scheduler #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT_VC0 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  vc_scheduler_if.master       bus
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_PAUSE  = 3'b011,
    ST_ACTIVE = 3'b100
  } state_t;

  localparam logic [3:0] WEIGHT = 4'(WEIGHT_VC0);

  state_t                st, st_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  pop0, pop1;
  logic                  vld1, src1;
  logic                  push0_q, push1_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  any_ne, any_af;
  logic [DATA_WIDTH-1:0] word;

  assign any_ne = !bus.empty_fifo_VC0 || !bus.empty_fifo_VC1;
  // The destination of a word is unknown until it is read, so any
  // almost_full blocks both VCs.
  assign any_af = bus.almost_full_D0 || bus.almost_full_D1;
  assign word   = src1 ? bus.data_out_VC1 : bus.data_out_VC0;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    pop0    = 1'b0;
    pop1    = 1'b0;
    case (st)
      ST_INIT: st_nxt = ST_IDLE;
      ST_IDLE: begin
        if (any_ne) st_nxt = any_af ? ST_PAUSE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!any_ne)     st_nxt = ST_IDLE;
        else if (any_af) st_nxt = ST_PAUSE;
        if (!any_af) begin
          if (!bus.empty_fifo_VC0 && bus.empty_fifo_VC1) begin
            pop0 = 1'b1;
          end else if (bus.empty_fifo_VC0 && !bus.empty_fifo_VC1) begin
            pop1    = 1'b1;
            cnt_nxt = 4'd0;
          end else if (!bus.empty_fifo_VC0 && !bus.empty_fifo_VC1) begin
            if (cnt < WEIGHT) begin
              pop0    = 1'b1;
              cnt_nxt = cnt + 4'd1;
            end else begin
              pop1    = 1'b1;
              cnt_nxt = 4'd0;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (!any_af) st_nxt = any_ne ? ST_ACTIVE : ST_IDLE;
      end
      default: st_nxt = ST_INIT;
    endcase
  end

  // Stage 1 (vld1/src1) marks the cycle the VC read data is valid; stage 2 is
  // the registered push, so a pop at N pushes at N+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= ST_INIT;
      cnt     <= 4'd0;
      vld1    <= 1'b0;
      src1    <= 1'b0;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      vld1    <= pop0 || pop1;
      src1    <= pop1;
      push0_q <= vld1 && !word[DEST_BIT];
      push1_q <= vld1 && word[DEST_BIT];
      if (vld1) data_q <= word;
      if ((push0_q && bus.full_D0) || (push1_q && bus.full_D1)) err_q <= 1'b1;
    end
  end

  assign bus.pop_VC0_fifo = pop0;
  assign bus.pop_VC1_fifo = pop1;
  assign bus.push_D0      = push0_q;
  assign bus.push_D1      = push1_q;
  assign bus.data_out_D   = data_q;
  assign bus.idle         = (st == ST_IDLE);
  assign bus.error_out    = err_q;
  assign bus.state        = st;

endmodule

// File: tb/tb_vc_scheduler.sv
module tb_vc_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vc_scheduler_if #(.DATA_WIDTH(6)) bus ();

  vc_scheduler #(.DATA_WIDTH(6), .DEST_BIT(4), .WEIGHT_VC0(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // VC FIFO models: memory/write pointer owned by the stimulus, read side here.
  // Read data appears the cycle after a pop; empty follows the pointers.
  logic [5:0] mem0 [64];
  logic [5:0] mem1 [64];
  int         wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic [5:0] rdata0 = '0, rdata1 = '0;

  always @(posedge clk) begin
    if (bus.pop_VC0_fifo) begin
      rdata0 <= mem0[rd0];
      rd0    <= rd0 + 1;
    end
    if (bus.pop_VC1_fifo) begin
      rdata1 <= mem1[rd1];
      rd1    <= rd1 + 1;
    end
  end

  assign bus.empty_fifo_VC0 = (rd0 == wr0);
  assign bus.empty_fifo_VC1 = (rd1 == wr1);
  assign bus.data_out_VC0   = rdata0;
  assign bus.data_out_VC1   = rdata1;

  logic [5:0] exp_q [$];
  int         exp_cyc [$];

  task automatic load_vc(input int vc, input logic [5:0] w);
    if (vc == 0) begin
      mem0[wr0] = w;
      wr0 = wr0 + 1;
    end else begin
      mem1[wr1] = w;
      wr1 = wr1 + 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.state !== 3'b001 || bus.idle !== 1'b0) begin
      failures++;
      $display("FAIL reset_init state=%b idle=%b exp state=001 idle=0", bus.state, bus.idle);
    end
    checks++;
    if ({bus.pop_VC0_fifo, bus.pop_VC1_fifo, bus.push_D0, bus.push_D1, bus.error_out} !== 5'b0 ||
        bus.data_out_D !== 6'h00) begin
      failures++;
      $display("FAIL reset_outputs pops=%b%b pushes=%b%b err=%b data=%h exp all 0",
               bus.pop_VC0_fifo, bus.pop_VC1_fifo, bus.push_D0, bus.push_D1, bus.error_out, bus.data_out_D);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.state !== 3'b010 || bus.idle !== 1'b1 || bus.pop_VC0_fifo !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle state=%b idle=%b pop0=%b exp state=010 idle=1 pop0=0",
               bus.state, bus.idle, bus.pop_VC0_fifo);
    end
  endtask

  task automatic test_single_vc0();
    logic [5:0] w;
    int pushes;
    pushes = 0;
    exp_q.delete();
    exp_cyc.delete();
    @(negedge clk);
    load_vc(0, 6'h05);
    load_vc(0, 6'h15);
    exp_q.push_back(6'h05);
    exp_q.push_back(6'h15);
    for (int c = 0; c < 30 && pushes < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.pop_VC1_fifo !== 1'b0) begin
        failures++;
        $display("FAIL single_pop_vc1 got=%b exp=0", bus.pop_VC1_fifo);
      end
      if (bus.pop_VC0_fifo) exp_cyc.push_back(c + 2);
      if (bus.push_D0 || bus.push_D1) begin
        pushes++;
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        if (bus.data_out_D !== w || bus.push_D1 !== w[4] || bus.push_D0 !== !w[4]) begin
          failures++;
          $display("FAIL single_push data=%h d0=%b d1=%b exp data=%h d1=%b", bus.data_out_D,
                   bus.push_D0, bus.push_D1, w, w[4]);
        end
        checks++;
        if (exp_cyc.size() == 0 || exp_cyc.pop_front() != c) begin
          failures++;
          $display("FAIL single_latency push at cycle %0d not 2 after its pop", c);
        end
      end
    end
    checks++;
    if (pushes != 2) begin
      failures++;
      $display("FAIL single_count pushes=%0d exp=2", pushes);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.state !== 3'b010 || bus.error_out !== 1'b0) begin
      failures++;
      $display("FAIL single_end state=%b err=%b exp state=010 err=0", bus.state, bus.error_out);
    end
  endtask

  task automatic test_weighted();
    bit   exp_g [$];
    logic [5:0] w0 [8];
    logic [5:0] w1 [8];
    logic [5:0] w;
    int n0, n1, k, i0, i1, pushes;
    bit g;
    do_reset();
    exp_q.delete();
    exp_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      w0[i] = 6'(i) | (((i % 2) == 1) ? 6'h10 : 6'h00);
      w1[i] = 6'h20 | 6'(i) | ((((i / 2) % 2) == 1) ? 6'h10 : 6'h00);
    end
    // Reference grant sequence: up to 3 VC0 grants per VC1 grant while both wait.
    n0 = 8; n1 = 8; k = 0; i0 = 0; i1 = 0;
    while (n0 > 0 || n1 > 0) begin
      if (n0 > 0 && n1 > 0) begin
        if (k < 3) begin g = 1'b0; k++; end
        else begin g = 1'b1; k = 0; end
      end else if (n0 > 0) begin
        g = 1'b0;
      end else begin
        g = 1'b1; k = 0;
      end
      exp_g.push_back(g);
      if (g) begin exp_q.push_back(w1[i1]); i1++; n1--; end
      else   begin exp_q.push_back(w0[i0]); i0++; n0--; end
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      load_vc(0, w0[i]);
      load_vc(1, w1[i]);
    end
    pushes = 0;
    for (int c = 0; c < 100 && pushes < 16; c++) begin
      @(negedge clk); #1;
      if (bus.pop_VC0_fifo || bus.pop_VC1_fifo) begin
        checks++;
        g = (exp_g.size() > 0) ? exp_g.pop_front() : 1'b0;
        if (bus.pop_VC0_fifo === bus.pop_VC1_fifo || bus.pop_VC1_fifo !== g) begin
          failures++;
          $display("FAIL weighted_grant pop0=%b pop1=%b exp grant VC%0d", bus.pop_VC0_fifo,
                   bus.pop_VC1_fifo, g);
        end
        exp_cyc.push_back(c + 2);
      end
      if (bus.push_D0 || bus.push_D1) begin
        pushes++;
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        if (bus.data_out_D !== w || bus.push_D1 !== w[4] || bus.push_D0 !== !w[4]) begin
          failures++;
          $display("FAIL weighted_push data=%h d0=%b d1=%b exp data=%h d1=%b", bus.data_out_D,
                   bus.push_D0, bus.push_D1, w, w[4]);
        end
        checks++;
        if (exp_cyc.size() == 0 || exp_cyc.pop_front() != c) begin
          failures++;
          $display("FAIL weighted_latency push at cycle %0d not 2 after its pop", c);
        end
      end
    end
    checks++;
    if (pushes != 16 || exp_g.size() != 0) begin
      failures++;
      $display("FAIL weighted_count pushes=%0d grants_left=%0d exp 16 and 0", pushes, exp_g.size());
    end
  endtask

  task automatic test_throttle();
    logic [5:0] w;
    int pushes, npop, af_cyc, drop_cyc, in_pause;
    do_reset();
    exp_q.delete();
    exp_cyc.delete();
    @(negedge clk);
    foreach (exp_q[i]) exp_q[i] = 6'h00;
    exp_q.push_back(6'h01); exp_q.push_back(6'h12); exp_q.push_back(6'h03);
    exp_q.push_back(6'h14); exp_q.push_back(6'h05); exp_q.push_back(6'h16);
    load_vc(0, 6'h01); load_vc(0, 6'h12); load_vc(0, 6'h03);
    load_vc(0, 6'h14); load_vc(0, 6'h05); load_vc(0, 6'h16);
    pushes = 0; npop = 0; af_cyc = -1; drop_cyc = -1; in_pause = 0;
    for (int c = 0; c < 60 && (pushes < 6 || drop_cyc < 0); c++) begin
      @(negedge clk);
      if (npop == 3 && af_cyc < 0) begin
        bus.almost_full_D1 = 1'b1;
        af_cyc = c;
      end
      if (af_cyc >= 0 && drop_cyc < 0 && c == af_cyc + 6) begin
        bus.almost_full_D1 = 1'b0;
        drop_cyc = c;
      end
      #1;
      if (af_cyc >= 0 && drop_cyc < 0) begin
        checks++;
        if (bus.pop_VC0_fifo || bus.pop_VC1_fifo ||
            (c > af_cyc && bus.state !== 3'b011)) begin
          failures++;
          $display("FAIL throttle_pause cycle=%0d pop0=%b state=%b exp pop0=0 state=011",
                   c, bus.pop_VC0_fifo, bus.state);
        end
      end
      if (drop_cyc >= 0 && c == drop_cyc) begin
        checks++;
        if (bus.pop_VC0_fifo !== 1'b0 || bus.state !== 3'b011) begin
          failures++;
          $display("FAIL throttle_drop pop0=%b state=%b exp pop0=0 state=011",
                   bus.pop_VC0_fifo, bus.state);
        end
      end
      if (drop_cyc >= 0 && c == drop_cyc + 1) begin
        checks++;
        if (bus.pop_VC0_fifo !== 1'b1 || bus.state !== 3'b100) begin
          failures++;
          $display("FAIL throttle_resume pop0=%b state=%b exp pop0=1 state=100",
                   bus.pop_VC0_fifo, bus.state);
        end
      end
      if (bus.pop_VC0_fifo) begin
        npop++;
        exp_cyc.push_back(c + 2);
      end
      if (bus.push_D0 || bus.push_D1) begin
        pushes++;
        if (af_cyc >= 0 && (drop_cyc < 0 || c <= drop_cyc)) in_pause++;
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        if (bus.data_out_D !== w || bus.push_D1 !== w[4] || bus.push_D0 !== !w[4]) begin
          failures++;
          $display("FAIL throttle_push data=%h d0=%b d1=%b exp data=%h d1=%b", bus.data_out_D,
                   bus.push_D0, bus.push_D1, w, w[4]);
        end
        checks++;
        if (exp_cyc.size() == 0 || exp_cyc.pop_front() != c) begin
          failures++;
          $display("FAIL throttle_latency push at cycle %0d not 2 after its pop", c);
        end
      end
    end
    bus.almost_full_D1 = 1'b0;
    checks++;
    if (pushes != 6 || in_pause != 2 || drop_cyc < 0) begin
      failures++;
      $display("FAIL throttle_count pushes=%0d in_pause=%0d exp pushes=6 in_pause=2", pushes, in_pause);
    end
  endtask

  task automatic test_full_error();
    logic [5:0] w;
    int pushes, err_cyc;
    do_reset();
    exp_q.delete();
    exp_cyc.delete();
    @(negedge clk);
    bus.full_D0 = 1'b1;
    load_vc(0, 6'h00);
    exp_q.push_back(6'h00);
    pushes = 0; err_cyc = -1;
    for (int c = 0; c < 40 && pushes < 3; c++) begin
      @(negedge clk);
      if (err_cyc >= 0 && c == err_cyc + 1) begin
        bus.full_D0 = 1'b0;
        load_vc(0, 6'h15);
        load_vc(0, 6'h02);
        exp_q.push_back(6'h15);
        exp_q.push_back(6'h02);
      end
      #1;
      checks++;
      if (bus.error_out !== ((err_cyc >= 0) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL full_error cycle=%0d err=%b exp=%b", c, bus.error_out, (err_cyc >= 0));
      end
      if (bus.pop_VC0_fifo) exp_cyc.push_back(c + 2);
      if (bus.push_D0 || bus.push_D1) begin
        pushes++;
        if (err_cyc < 0) err_cyc = c;
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        if (bus.data_out_D !== w || bus.push_D1 !== w[4] || bus.push_D0 !== !w[4]) begin
          failures++;
          $display("FAIL full_push data=%h d0=%b d1=%b exp data=%h d1=%b", bus.data_out_D,
                   bus.push_D0, bus.push_D1, w, w[4]);
        end
        checks++;
        if (exp_cyc.size() == 0 || exp_cyc.pop_front() != c) begin
          failures++;
          $display("FAIL full_latency push at cycle %0d not 2 after its pop", c);
        end
      end
    end
    bus.full_D0 = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (pushes != 3 || bus.error_out !== 1'b1) begin
      failures++;
      $display("FAIL full_sticky pushes=%0d err=%b exp pushes=3 err=1", pushes, bus.error_out);
    end
  endtask

  task automatic test_reset_inflight();
    bit seen;
    int c;
    do_reset();
    @(negedge clk);
    load_vc(0, 6'h07);
    load_vc(0, 6'h08);
    load_vc(1, 6'h21);
    seen = 1'b0;
    c = 0;
    while (!seen && c < 10) begin
      @(negedge clk); #1;
      if (bus.pop_VC0_fifo || bus.pop_VC1_fifo) seen = 1'b1;
      c++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rstflt_pop no pop within %0d cycles", c);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk); #1;
    checks++;
    if (bus.push_D0 !== 1'b0 || bus.push_D1 !== 1'b0) begin
      failures++;
      $display("FAIL rstflt_push d0=%b d1=%b exp 0 0", bus.push_D0, bus.push_D1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.state !== 3'b001 || bus.data_out_D !== 6'h00 || dut.cnt !== 4'd0 ||
        bus.push_D0 !== 1'b0 || bus.push_D1 !== 1'b0) begin
      failures++;
      $display("FAIL rstflt_init state=%b data=%h cnt=%0d d0=%b d1=%b exp 001 00 0 0 0",
               bus.state, bus.data_out_D, dut.cnt, bus.push_D0, bus.push_D1);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.state !== 3'b010 || bus.push_D0 !== 1'b0 || bus.push_D1 !== 1'b0) begin
      failures++;
      $display("FAIL rstflt_idle state=%b d0=%b d1=%b exp 010 0 0", bus.state, bus.push_D0, bus.push_D1);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    bus.almost_full_D0 = 1'b0;
    bus.almost_full_D1 = 1'b0;
    bus.full_D0 = 1'b0;
    bus.full_D1 = 1'b0;
    test_reset();
    test_single_vc0();
    test_weighted();
    test_throttle();
    test_full_error();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
